// File: rtl/irq_ctrl_pkg.sv
// Shared constants and helpers for the interrupt controller: register offsets,
// ACTIVE register field position, byte-lane merge and priority encoding.
package irq_ctrl_pkg;

    localparam logic [4:0] REG_RAW      = 5'h00;
    localparam logic [4:0] REG_ENABLE   = 5'h04;
    localparam logic [4:0] REG_MODE     = 5'h08;
    localparam logic [4:0] REG_POLARITY = 5'h0C;
    localparam logic [4:0] REG_PENDING  = 5'h10;
    localparam logic [4:0] REG_ACTIVE   = 5'h14;

    localparam int ACTIVE_VALID_BIT = 31;

    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    // Scanning downward leaves the lowest set index as the final assignment.
    function automatic logic [4:0] lowest_set(input logic [31:0] vec);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 5'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// One interrupt channel front end: multi-flop synchroniser, polarity
// inversion to an active level, and a rising-edge detector on that level.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    input  logic polarity,
    input  logic edge_mask,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;

    // Synchroniser shift chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], irq_in};
        end
    end

    // Previous active level for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_r <= 1'b0;
        end else begin
            hist_r <= level;
        end
    end

    // A polarity change flips the level without a real source edge; edge_mask hides that cycle.
    assign level = sync_r[SYNC_STAGES-1] ^ polarity;
    assign rise  = level & ~hist_r & ~edge_mask;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-channel synchronisation and edge/level capture,
// a small register bank on a one-cycle-ack bus, and registered CPU outputs.
module irq_ctrl #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               bus_valid,
    input  logic [4:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    input  logic [3:0]         bus_wstrb,
    output logic               bus_ready,
    output logic [31:0]        bus_rdata,
    output logic [31:0]        irq_out,
    output logic               irq_req,
    output logic [4:0]         irq_id
);
    import irq_ctrl_pkg::*;

    localparam logic [31:0] CHAN_MASK = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                                         : ((32'h1 << NUM_IRQ) - 32'h1);

    logic [31:0] level_s;
    logic [31:0] rise_s;
    logic [31:0] enable_r;
    logic [31:0] mode_r;
    logic [31:0] polarity_r;
    logic [31:0] pending_r;
    logic        pol_mask_r;
    logic        bus_ready_r;
    logic [31:0] bus_rdata_r;
    logic [31:0] irq_out_r;
    logic        irq_req_r;
    logic [4:0]  irq_id_r;

    logic [4:0]  reg_addr_s;
    logic        access_s;
    logic        wr_s;
    logic        rd_s;
    logic        pol_wr_s;
    logic [31:0] wmask_s;
    logic [31:0] enable_nxt_s;
    logic [31:0] mode_nxt_s;
    logic [31:0] polarity_nxt_s;
    logic [31:0] w1c_s;
    logic [31:0] pending_nxt_s;
    logic [31:0] rd_mux_s;
    logic [31:0] active_word_s;
    logic [31:0] out_vec_s;
    logic        unused_addr_s;

    assign unused_addr_s = ^bus_addr[1:0];

    for (genvar i = 0; i < 32; i++) begin : g_chan
        if (i < NUM_IRQ) begin : g_used
            irq_sync #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .clk       (clk),
                .reset     (reset),
                .irq_in    (irq_in[i]),
                .polarity  (polarity_r[i]),
                .edge_mask (pol_mask_r),
                .level     (level_s[i]),
                .rise      (rise_s[i])
            );
        end else begin : g_unused
            assign level_s[i] = 1'b0;
            assign rise_s[i]  = 1'b0;
        end
    end

    // Bus decode and next-state computation for the register bank
    always_comb begin
        reg_addr_s     = {bus_addr[4:2], 2'b00};
        access_s       = bus_valid & ~bus_ready_r;
        wr_s           = access_s & (|bus_wstrb);
        rd_s           = access_s & ~(|bus_wstrb);
        wmask_s        = lane_mask(bus_wstrb) & CHAN_MASK;
        enable_nxt_s   = enable_r;
        mode_nxt_s     = mode_r;
        polarity_nxt_s = polarity_r;
        w1c_s          = 32'h0;
        pol_wr_s       = 1'b0;
        if (wr_s) begin
            case (reg_addr_s)
                REG_ENABLE:   enable_nxt_s = merge_bytes(enable_r, bus_wdata, wmask_s);
                REG_MODE:     mode_nxt_s   = merge_bytes(mode_r, bus_wdata, wmask_s);
                REG_POLARITY: begin
                    polarity_nxt_s = merge_bytes(polarity_r, bus_wdata, wmask_s);
                    pol_wr_s       = 1'b1;
                end
                REG_PENDING:  w1c_s = bus_wdata & wmask_s;
                default:      w1c_s = 32'h0;
            endcase
        end else begin
            w1c_s = 32'h0;
        end
        // Edge bits: a new rise beats a simultaneous W1C. Level bits track the level.
        pending_nxt_s = ((mode_r & ((pending_r & ~w1c_s) | rise_s)) | (~mode_r & level_s))
                        & ~(mode_nxt_s ^ mode_r) & CHAN_MASK;
    end

    // Read data selection
    always_comb begin
        active_word_s                   = {27'd0, irq_id_r};
        active_word_s[ACTIVE_VALID_BIT] = irq_req_r;
        case (reg_addr_s)
            REG_RAW:      rd_mux_s = level_s;
            REG_ENABLE:   rd_mux_s = enable_r;
            REG_MODE:     rd_mux_s = mode_r;
            REG_POLARITY: rd_mux_s = polarity_r;
            REG_PENDING:  rd_mux_s = pending_r;
            REG_ACTIVE:   rd_mux_s = active_word_s;
            default:      rd_mux_s = 32'h0;
        endcase
    end

    assign out_vec_s = pending_r & enable_r;

    // Register bank and pending state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_r   <= 32'h0;
            mode_r     <= 32'h0;
            polarity_r <= 32'h0;
            pending_r  <= 32'h0;
            pol_mask_r <= 1'b0;
        end else begin
            enable_r   <= enable_nxt_s;
            mode_r     <= mode_nxt_s;
            polarity_r <= polarity_nxt_s;
            pending_r  <= pending_nxt_s;
            pol_mask_r <= pol_wr_s;
        end
    end

    // Bus handshake: accept on a non-ready cycle, acknowledge the next one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_ready_r <= 1'b0;
            bus_rdata_r <= 32'h0;
        end else if (access_s) begin
            bus_ready_r <= 1'b1;
            bus_rdata_r <= rd_s ? rd_mux_s : 32'h0;
        end else begin
            bus_ready_r <= 1'b0;
            bus_rdata_r <= 32'h0;
        end
    end

    // CPU-facing interrupt outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_out_r <= 32'h0;
            irq_req_r <= 1'b0;
            irq_id_r  <= 5'd0;
        end else begin
            irq_out_r <= out_vec_s;
            irq_req_r <= |out_vec_s;
            irq_id_r  <= lowest_set(out_vec_s);
        end
    end

    assign bus_ready = bus_ready_r;
    assign bus_rdata = bus_rdata_r;
    assign irq_out   = irq_out_r;
    assign irq_req   = irq_req_r;
    assign irq_id    = irq_id_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: register table, scoreboarded bus reads and
// hand-written multi-cycle interrupt sequences; a NUM_IRQ=3 instance checks masking.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  irq_in = 8'h00;
    logic        bus_valid = 1'b0;
    logic [4:0]  bus_addr = 5'h00;
    logic [31:0] bus_wdata = 32'h0;
    logic [3:0]  bus_wstrb = 4'h0;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic [31:0] irq_out;
    logic        irq_req;
    logic [4:0]  irq_id;

    logic [2:0]  b3_irq_in = 3'b000;
    logic        b3_valid = 1'b0;
    logic [4:0]  b3_addr = 5'h00;
    logic [31:0] b3_wdata = 32'h0;
    logic [3:0]  b3_wstrb = 4'h0;
    logic        b3_ready;
    logic [31:0] b3_rdata;
    logic [31:0] b3_irq_out;
    logic        b3_irq_req;
    logic [4:0]  b3_irq_id;

    always #5 clk = ~clk;

    irq_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .reset(reset), .irq_in(irq_in),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .irq_out(irq_out), .irq_req(irq_req), .irq_id(irq_id)
    );

    irq_ctrl #(.NUM_IRQ(3), .SYNC_STAGES(3)) u_dut3 (
        .clk(clk), .reset(reset), .irq_in(b3_irq_in),
        .bus_valid(b3_valid), .bus_addr(b3_addr), .bus_wdata(b3_wdata), .bus_wstrb(b3_wstrb),
        .bus_ready(b3_ready), .bus_rdata(b3_rdata),
        .irq_out(b3_irq_out), .irq_req(b3_irq_req), .irq_id(b3_irq_id)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
        bit          chk;
    } sb_item_t;

    typedef struct {
        string       name;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    sb_item_t sb_q[$];
    sb_item_t sb_head;
    int       vectors = 0;
    int       miscompares = 0;

    // Scoreboard: every ready pulse pops the oldest outstanding access
    always @(negedge clk) begin
        if (bus_ready) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_ready: bus_ready=1 with no access outstanding, expected 0");
            end else begin
                sb_head = sb_q.pop_front();
                if (sb_head.chk) begin
                    vectors++;
                    if (bus_rdata !== sb_head.exp) begin
                        miscompares++;
                        $display("FAIL %s: rdata=%h expected %h", sb_head.name, bus_rdata, sb_head.exp);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_xfer(input string name, input logic [4:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [31:0] e);
        sb_item_t it;
        bit       got;
        @(negedge clk);
        bus_addr  = a;
        bus_wdata = d;
        bus_wstrb = s;
        bus_valid = 1'b1;
        it.name = name;
        it.exp  = e;
        it.chk  = (s == 4'h0);
        sb_q.push_back(it);
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!got) begin
                @(posedge clk);
                #1;
                got = bus_ready;
            end
        end
        bus_valid = 1'b0;
        bus_wstrb = 4'h0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: no bus_ready within 8 cycles, expected one", name);
            void'(sb_q.pop_back());
        end
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] e);
        bus_xfer(name, a, 32'h0, 4'h0, e);
    endtask

    task automatic wr(input string name, input logic [4:0] a, input logic [31:0] d);
        bus_xfer(name, a, d, 4'hF, 32'h0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer3(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rdata);
        bit got;
        @(negedge clk);
        b3_addr  = a;
        b3_wdata = d;
        b3_wstrb = s;
        b3_valid = 1'b1;
        got   = 1'b0;
        rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 8; k++) begin
            if (!got) begin
                @(posedge clk);
                #1;
                if (b3_ready) begin
                    got   = 1'b1;
                    rdata = b3_rdata;
                end
            end
        end
        b3_valid = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL dut3_timeout: no bus_ready within 8 cycles, expected one");
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        int          rdy_cnt;
        logic [31:0] r3;

        tbl.push_back('{"en_all",      REG_ENABLE,   32'hFFFF_FFFF, 4'hF, 32'h0});
        tbl.push_back('{"en_rd_ff",    REG_ENABLE,   32'h0,         4'h0, 32'h0000_00FF});
        tbl.push_back('{"en_lane0",    REG_ENABLE,   32'h0000_AA55, 4'h1, 32'h0});
        tbl.push_back('{"en_rd_55",    REG_ENABLE,   32'h0,         4'h0, 32'h0000_0055});
        tbl.push_back('{"en_lane1",    REG_ENABLE,   32'h0000_1200, 4'h2, 32'h0});
        tbl.push_back('{"en_rd_lane1", REG_ENABLE,   32'h0,         4'h0, 32'h0000_0055});
        tbl.push_back('{"mode_wr",     REG_MODE,     32'h0000_003C, 4'hF, 32'h0});
        tbl.push_back('{"mode_rd",     REG_MODE,     32'h0,         4'h0, 32'h0000_003C});
        tbl.push_back('{"mode_rd_lsb", 5'h0B,        32'h0,         4'h0, 32'h0000_003C});
        tbl.push_back('{"unmap_wr",    5'h18,        32'hFFFF_FFFF, 4'hF, 32'h0});
        tbl.push_back('{"unmap_rd18",  5'h18,        32'h0,         4'h0, 32'h0});
        tbl.push_back('{"unmap_rd1c",  5'h1C,        32'h0,         4'h0, 32'h0});
        tbl.push_back('{"raw_wr",      REG_RAW,      32'h0000_00FF, 4'hF, 32'h0});
        tbl.push_back('{"raw_rd",      REG_RAW,      32'h0,         4'h0, 32'h0});
        tbl.push_back('{"mode_clr",    REG_MODE,     32'h0,         4'hF, 32'h0});
        tbl.push_back('{"mode_rd0",    REG_MODE,     32'h0,         4'h0, 32'h0});
        tbl.push_back('{"en_clr",      REG_ENABLE,   32'h0,         4'hF, 32'h0});
        tbl.push_back('{"en_rd0",      REG_ENABLE,   32'h0,         4'h0, 32'h0});
        tbl.push_back('{"pend_rd0",    REG_PENDING,  32'h0,         4'h0, 32'h0});
        tbl.push_back('{"active_rd0",  REG_ACTIVE,   32'h0,         4'h0, 32'h0});

        // Reset state
        cycles(3);
        check("rst_ready", {31'd0, bus_ready}, 32'h0);
        check("rst_rdata", bus_rdata, 32'h0);
        check("rst_irq_out", irq_out, 32'h0);
        check("rst_irq_req", {31'd0, irq_req}, 32'h0);
        check("rst_irq_id", {27'd0, irq_id}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            bus_xfer(tbl[i].name, tbl[i].addr, tbl[i].wdata, tbl[i].strb, tbl[i].exp);
        end

        // Edge-mode pulse on channel 5: exact SYNC_STAGES+2 latency, then W1C
        wr("en20", REG_ENABLE, 32'h20);
        wr("modeff", REG_MODE, 32'hFF);
        @(posedge clk);
        #1 irq_in[5] = 1'b1;
        cycles(3);
        check("lat_irq_out_early", irq_out, 32'h0);
        cycles(1);
        check("lat_irq_out", irq_out, 32'h20);
        check("lat_irq_id", {27'd0, irq_id}, 32'd5);
        check("lat_irq_req", {31'd0, irq_req}, 32'h1);
        rd("active_5", REG_ACTIVE, 32'h8000_0005);
        cycles(14);
        irq_in[5] = 1'b0;
        cycles(4);
        rd("pend_after_fall", REG_PENDING, 32'h20);
        wr("w1c5", REG_PENDING, 32'h20);
        cycles(2);
        check("w1c_irq_out", irq_out, 32'h0);
        check("w1c_irq_req", {31'd0, irq_req}, 32'h0);

        // Edge on channel 5 lands on the same edge as its W1C
        @(posedge clk);
        #1 irq_in[5] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus_addr  = REG_PENDING;
        bus_wdata = 32'h20;
        bus_wstrb = 4'hF;
        bus_valid = 1'b1;
        sb_q.push_back('{"w1c_collide", 32'h0, 1'b0});
        @(posedge clk);
        #1;
        bus_valid = 1'b0;
        bus_wstrb = 4'h0;
        cycles(3);
        rd("pend_set_wins", REG_PENDING, 32'h20);
        irq_in[5] = 1'b0;
        wr("w1c5b", REG_PENDING, 32'h20);

        // Simultaneous edges on 6 and 7: lowest index wins
        wr("enc0", REG_ENABLE, 32'hC0);
        irq_in[7:6] = 2'b11;
        cycles(6);
        check("both_irq_out", irq_out, 32'hC0);
        check("both_irq_id", {27'd0, irq_id}, 32'd6);
        wr("w1c6", REG_PENDING, 32'h40);
        cycles(2);
        check("after_w1c6_id", {27'd0, irq_id}, 32'd7);
        wr("dis_all", REG_ENABLE, 32'h0);
        cycles(1);
        check("disable_irq_out", irq_out, 32'h0);
        rd("disable_keeps_pend", REG_PENDING, 32'h80);
        irq_in[7:6] = 2'b00;
        wr("w1c7", REG_PENDING, 32'h80);

        // Polarity flip must not create an edge; a real falling source does
        wr("en80", REG_ENABLE, 32'h80);
        wr("pol80", REG_POLARITY, 32'h80);
        cycles(5);
        rd("pol_no_spurious", REG_PENDING, 32'h0);
        rd("pol_raw", REG_RAW, 32'h80);
        irq_in[7] = 1'b1;
        cycles(5);
        irq_in[7] = 1'b0;
        cycles(5);
        rd("pol_fall_edge", REG_PENDING, 32'h80);
        wr("pol00", REG_POLARITY, 32'h0);
        wr("w1c7b", REG_PENDING, 32'h80);

        // Level mode on channel 0: W1C ignored, clears with the source
        wr("mode00", REG_MODE, 32'h0);
        wr("en01", REG_ENABLE, 32'h01);
        irq_in[0] = 1'b1;
        cycles(5);
        rd("lvl_pend", REG_PENDING, 32'h01);
        wr("lvl_w1c", REG_PENDING, 32'h01);
        rd("lvl_pend_w1c", REG_PENDING, 32'h01);
        @(posedge clk);
        #1 irq_in[0] = 1'b0;
        cycles(3);
        check("lvl_out_hold", irq_out, 32'h01);
        cycles(1);
        check("lvl_out_clear", irq_out, 32'h0);

        // bus_valid held high: one ready every two cycles
        @(negedge clk);
        bus_addr  = REG_ENABLE;
        bus_wstrb = 4'h0;
        bus_valid = 1'b1;
        sb_q.push_back('{"held_rd_a", 32'h01, 1'b1});
        sb_q.push_back('{"held_rd_b", 32'h01, 1'b1});
        rdy_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("held_ready_c%0d", k), {31'd0, bus_ready}, (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        bus_valid = 1'b0;

        // Reset in the middle of a read: no ready, everything cleared
        wr("pol03", REG_POLARITY, 32'h03);
        wr("mode02", REG_MODE, 32'h02);
        cycles(5);
        check("pre_rst_irq_out", irq_out, 32'h01);
        @(negedge clk);
        bus_addr  = REG_ENABLE;
        bus_wstrb = 4'h0;
        bus_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_irq_out", irq_out, 32'h0);
        check("mid_rst_ready", {31'd0, bus_ready}, 32'h0);
        @(posedge clk);
        #1 bus_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        rdy_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (bus_ready) rdy_cnt++;
        end
        check("rst_abort_ready", 32'(rdy_cnt), 32'h0);
        rd("post_rst_raw", REG_RAW, 32'h0);
        rd("post_rst_en", REG_ENABLE, 32'h0);
        rd("post_rst_mode", REG_MODE, 32'h0);
        rd("post_rst_pol", REG_POLARITY, 32'h0);
        rd("post_rst_pend", REG_PENDING, 32'h0);
        rd("post_rst_active", REG_ACTIVE, 32'h0);
        check("post_rst_irq_out", irq_out, 32'h0);

        // Narrow build masks unimplemented channels
        xfer3(REG_ENABLE, 32'hFFFF_FFFF, 4'hF, r3);
        xfer3(REG_ENABLE, 32'h0, 4'h0, r3);
        check("n3_enable", r3, 32'h7);
        xfer3(REG_POLARITY, 32'hFFFF_FFFF, 4'hF, r3);
        xfer3(REG_RAW, 32'h0, 4'h0, r3);
        check("n3_raw", r3, 32'h7);

        cycles(3);
        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 8: number of interrupt channels, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth per channel, legal range 2..3.
REQ-003 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 irq_in  input  NUM_IRQ  raw asynchronous interrupt sources.
REQ-006 bus_valid  input  1  register access request.
REQ-007 bus_addr  input  5  byte address; bits [1:0] are ignored.
REQ-008 bus_wdata  input  32  write data.
REQ-009 bus_wstrb  input  4  byte write enables; all zero denotes a read.
REQ-010 bus_ready  output  1  one-cycle access acknowledge.
REQ-011 bus_rdata  output  32  registered read data, valid while bus_ready=1.
REQ-012 irq_out  output  32  registered pending&enable vector to the CPU; bits >= NUM_IRQ are 0.
REQ-013 irq_req  output  1  registered OR of irq_out.
REQ-014 irq_id  output  5  registered index of the lowest-numbered set bit of irq_out; 0 when none is set.

Function
REQ-015 Each irq_in bit SHALL pass through SYNC_STAGES flops, then be XORed with its POLARITY bit to form the active level.
REQ-016 Register map: 0x00 RAW (RO, active levels), 0x04 ENABLE (RW), 0x08 MODE (RW, 1=edge, 0=level), 0x0C POLARITY (RW, 1=active-low), 0x10 PENDING (RO in level mode, W1C in edge mode), 0x14 ACTIVE (RO: bit31=irq_req, bits[4:0]=irq_id).
REQ-017 Bits >= NUM_IRQ SHALL read 0 and ignore writes; unmapped addresses SHALL read 0 and ignore writes.
REQ-018 Writes SHALL honour bus_wstrb per byte lane.
REQ-019 bus_ready SHALL pulse for exactly one cycle, on the cycle after bus_valid is first sampled high.
REQ-020 No new access SHALL be accepted in the bus_ready cycle; bus_valid held high SHALL yield one ready every 2 cycles.
REQ-021 Register writes SHALL take effect at the bus_ready edge.
REQ-022 Edge mode: PENDING[i] SHALL be set on a 0->1 transition of the active level.
REQ-023 Edge mode: a set and a W1C of the same bit in the same cycle SHALL leave the bit set.
REQ-024 Level mode: PENDING[i] SHALL equal the registered active level; W1C SHALL have no effect.
REQ-025 A MODE change SHALL clear PENDING[i] for every bit whose mode changes.
REQ-026 Edge detection SHALL be masked for one cycle after a POLARITY write, so no spurious edge results.
REQ-027 irq_out, irq_req and irq_id SHALL be registered from PENDING&ENABLE.
REQ-028 Latency from the irq_in edge to irq_out SHALL be SYNC_STAGES+2 cycles.
REQ-029 Disabling a channel SHALL clear its irq_out bit the next cycle without clearing PENDING.

Reset
REQ-030 Asserting reset SHALL immediately clear all synchroniser flops, edge-history flops, ENABLE, MODE, POLARITY, PENDING, bus_ready, bus_rdata, irq_out, irq_req and irq_id.
REQ-031 Reset asserted during a bus access SHALL abort the access; no ready pulse SHALL follow.

Structure
REQ-032 Package irq_ctrl_pkg SHALL hold the register offset constants and a field constant for the ACTIVE valid bit (31).
REQ-033 Sub-module irq_sync SHALL hold one channel's synchroniser, polarity XOR and edge detector; it SHALL be instantiated NUM_IRQ times via generate.

Verification
REQ-034 Defaults, edge mode, ENABLE=0x20, MODE=0xFF: 20-cycle pulse on irq_in[5] -> irq_out=0x20, irq_id=5 after 4 cycles; W1C 0x20 to 0x10 -> irq_out=0 and irq_req=0.
REQ-035 Level mode, ENABLE=0x01: irq_in[0] high -> PENDING=0x01; W1C has no effect; irq_in[0] low -> PENDING=0 after 3 cycles.
REQ-036 Simultaneous irq_in[6] and irq_in[7] edges, ENABLE=0xC0 -> irq_id=6; W1C bit 6 -> irq_id=7.
REQ-037 POLARITY=0x80 write with irq_in[7] steady low, edge mode -> PENDING stays 0; irq_in[7] rises then falls -> PENDING[7]=1.
REQ-038 irq_in[5] edge on the same cycle as a W1C of bit 5 -> PENDING[5]=1 remains.
REQ-039 Reset asserted mid-read -> no bus_ready pulse; all registers and outputs read 0; NUM_IRQ=3 build -> reads of ENABLE after writing 0xFFFFFFFF return 0x7.
